// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a runtime-loadable pattern, overlap select and a saturating match counter.
// Optional build macro SEQ_DET_MASK_EN adds a per-bit don't-care mask (pat_mask) loaded with the pattern.
module seq_detector_param #(
    parameter int                 PAT_LEN         = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PATTERN = 4'b1011,
    parameter int                 CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_LEN-1:0] pat_mask,
`endif
    input  logic               overlap_en,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    localparam int                FILL_W  = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // The oldest history bit is shifted out on every consumed bit, so only PAT_LEN-1 bits are kept.
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] hist_n;
    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cmp_ok;
    logic               hit;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0] mask_q, mask_d;
    assign cmp_ok = ((hist_n ^ pattern_q) & mask_q) == '0;
`else
    assign cmp_ok = (hist_n == pattern_q);
`endif

    assign hist_n = {hist_q, in_bit};
    assign fill_n = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    assign hit    = in_valid && !pat_load && (fill_n == FULL) && cmp_ok;

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        match_d   = 1'b0;
        count_d   = count_q;
`ifdef SEQ_DET_MASK_EN
        mask_d    = mask_q;
`endif
        if (pat_load) begin
            pattern_d = pat_in;
            hist_d    = '0;
            fill_d    = '0;
`ifdef SEQ_DET_MASK_EN
            mask_d    = pat_mask;
`endif
        end else if (in_valid) begin
            hist_d  = hist_n[PAT_LEN-2:0];
            fill_d  = (hit && !overlap_en) ? '0 : fill_n;
            match_d = hit;
        end
        // Clear beats a simultaneous hit; the pulse itself is still issued.
        if (count_clr) begin
            count_d = '0;
        end else if (hit) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= DEFAULT_PATTERN;
            match_q   <= 1'b0;
            count_q   <= '0;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            match_q   <= match_d;
            count_q   <= count_d;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign match       = match_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: vector table, directed corner sequences and a queue-based random reference model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic [3:0] pat_mask = 4'b1111;
    logic       overlap_en = 1'b1;
    logic       count_clr = 1'b0;
    logic       match8, match2;
    logic [7:0] count8;
    logic [1:0] count2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .DEFAULT_PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .overlap_en(overlap_en), .count_clr(count_clr),
        .match(match8), .match_count(count8)
    );

    seq_detector_param #(.PAT_LEN(4), .DEFAULT_PATTERN(4'b1011), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .overlap_en(overlap_en), .count_clr(count_clr),
        .match(match2), .match_count(count2)
    );

    // Reference model: bits received since the last restart, newest at the back.
    logic       win[$];
    logic [3:0] m_pat  = 4'b1011;
    logic [3:0] m_mask = 4'b1111;
    logic       m_match = 1'b0;
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        logic       hit;
        logic [3:0] v;
        hit = 1'b0;
        if (rst) begin
            win.delete();
            m_pat  = 4'b1011;
            m_mask = 4'b1111;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            if (pat_load) begin
                m_pat = pat_in;
`ifdef SEQ_DET_MASK_EN
                m_mask = pat_mask;
`endif
                win.delete();
            end else if (in_valid) begin
                win.push_back(in_bit);
                if (win.size() > 4) void'(win.pop_front());
                if (win.size() == 4) begin
                    v = 4'b0000;
                    for (int i = 0; i < 4; i++) v = {v[2:0], win[i]};
                    hit = ((v ^ m_pat) & m_mask) == 4'b0000;
                end
                if (hit && !overlap_en) win.delete();
            end
            if (count_clr) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (hit) begin
                m_cnt8 = (m_cnt8 == 255) ? 255 : m_cnt8 + 1;
                m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
            end
        end
        m_match = hit;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_match8", 32'(match8), 32'(m_match));
        chk("model_match2", 32'(match2), 32'(m_match));
        chk("model_count8", 32'(count8), 32'(m_cnt8));
        chk("model_count2", 32'(count2), 32'(m_cnt2));
    endtask

    task automatic idle_ctl();
        rst = 1'b0; pat_load = 1'b0; count_clr = 1'b0; in_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_ctl();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic feed(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m);
        pat_load = 1'b1; pat_in = p; pat_mask = m;
        tick();
        pat_load = 1'b0;
    endtask

    typedef struct {
        logic rst, vld, b, ovl;
        logic exp_m;
        int   exp_c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic vl, logic b, logic o, logic em, int ec);
        vec_t t;
        t.rst = r; t.vld = vl; t.b = b; t.ovl = o; t.exp_m = em; t.exp_c = ec;
        return t;
    endfunction

    initial begin
        logic [3:0] sb;
        // Overlap: 1011011 hits after bits 4 and 7.
        tbl.push_back(mk(1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 2));
        // Non-overlap: same stream, single hit.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1));

        idle_ctl();
        rst = 1'b1;
        tick();
        chk("reset_match", 32'(match8), 32'd0);
        chk("reset_count", 32'(count8), 32'd0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_bit = tbl[i].b;
            overlap_en = tbl[i].ovl; pat_load = 1'b0; count_clr = 1'b0;
            tick();
            chk($sformatf("tbl%0d_match", i), 32'(match8), 32'(tbl[i].exp_m));
            chk($sformatf("tbl%0d_count", i), 32'(count8), 32'(tbl[i].exp_c));
        end

        // Gapped input with junk on in_bit during idle cycles.
        do_reset();
        overlap_en = 1'b1;
        sb = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            feed(sb[i]);
            chk("gap_valid_match", 32'(match8), (i == 0) ? 32'd1 : 32'd0);
            in_valid = 1'b0; in_bit = 1'($urandom);
            tick();
            chk("gap_idle_match", 32'(match8), 32'd0);
        end
        chk("gap_count", 32'(count8), 32'd1);

        // Reload mid-stream; the bit offered with the load is discarded.
        do_reset();
        feed(1); feed(0); feed(1);
        pat_load = 1'b1; pat_in = 4'b0110; pat_mask = 4'b1111; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        pat_load = 1'b0; in_valid = 1'b0;
        chk("reload_match", 32'(match8), 32'd0);
        feed(0); feed(1); feed(1);
        chk("reload_pre_match", 32'(match8), 32'd0);
        feed(0);
        chk("reload_hit", 32'(match8), 32'd1);
        chk("reload_count", 32'(count8), 32'd1);

        // Saturation on the 2-bit counter, then clear colliding with a hit.
        do_reset();
        load(4'b1111, 4'b1111);
        overlap_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            feed(1);
            chk("sat_match", 32'(match2), (i >= 3) ? 32'd1 : 32'd0);
            chk("sat_count2", 32'(count2), (i < 3) ? 32'd0 : ((i == 3) ? 32'd1 : ((i == 4) ? 32'd2 : 32'd3)));
        end
        count_clr = 1'b1;
        feed(1);
        count_clr = 1'b0;
        chk("clr_hit_match", 32'(match2), 32'd1);
        chk("clr_hit_count2", 32'(count2), 32'd0);
        chk("clr_hit_count8", 32'(count8), 32'd0);

`ifdef SEQ_DET_MASK_EN
        do_reset();
        overlap_en = 1'b0;
        load(4'b1011, 4'b1101);
        feed(1); feed(0); feed(0); feed(1);
        chk("mask_hit", 32'(match8), 32'd1);
        feed(0); feed(0); feed(1); feed(1);
        chk("mask_nohit", 32'(match8), 32'd0);
        feed(1); feed(0);
        do_reset();
        chk("mask_rst_count", 32'(count8), 32'd0);
        feed(1); feed(0); feed(0); feed(1);
        chk("mask_rst_nohit", 32'(match8), 32'd0);
        do_reset();
        feed(1); feed(0); feed(1); feed(1);
        chk("mask_rst_default_hit", 32'(match8), 32'd1);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            pat_load   = ($urandom_range(0, 39) == 0);
            pat_in     = 4'($urandom);
            pat_mask   = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
            count_clr  = ($urandom_range(0, 59) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_bit     = 1'($urandom);
            if ($urandom_range(0, 9) == 0) overlap_en = ~overlap_en;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
